// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
//   Shared constants for the store-side IO path: the blank/off codes for the
//   7-segment display, the hex-to-cathode glyph table, and the IO addresses
//   that the memory/IO mux decodes into led_ctrl / seg_ctrl.
//   Cathode bit order is {dp,g,f,e,d,c,b,a}. All cathode bits are active low.
// ----------------------------------------------------------------------------
package io_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;  // all cathodes off
    localparam logic [7:0] SEG_OFF_AN = 8'hFF;  // all anodes off

    localparam logic [31:0] LED_ADR = 32'hFFFF_FC60;
    localparam logic [31:0] SEG_ADR = 32'hFFFF_FC00;

    // Glyphs for 0-F with the decimal point always off (bit 7 set).
    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,   // 0 1 2 3
        8'h99, 8'h92, 8'h82, 8'hF8,   // 4 5 6 7
        8'h80, 8'h90, 8'h88, 8'h83,   // 8 9 A b
        8'hC6, 8'hA1, 8'h86, 8'h8E    // C d E F
    };

endpackage

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
//   Combinational hex nibble to 7-segment cathode decoder.
//   Ports:
//     nibble   in   4   hex digit value
//     cathode  out  8   {dp,g,f,e,d,c,b,a}, active low, dp always off
// ----------------------------------------------------------------------------
module seg7_decode
    import io_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] cathode
);

    always_comb begin
        cathode = HEX_GLYPH[nibble];
    end

endmodule

// File: rtl/io_out_driver.sv
// ----------------------------------------------------------------------------
// io_out_driver
//   Store-side output peripheral. Latches write data from the memory/IO mux
//   into a 16-bit LED register and a 32-bit display register, then scans the
//   display across 8 multiplexed 7-segment digits.
//   Parameters:
//     SCAN_DIV    clk cycles per digit slot (>= 2)
//     BLANK_LEAD  1 = blank leading zero digits (digit 0 always shown)
//   Ports:
//     clk        in   1   system clock
//     rst_n      in   1   asynchronous reset, active low
//     led_ctrl   in   1   latch w_dat[15:0] into the LED register
//     seg_ctrl   in   1   latch w_dat into the display register
//     w_dat      in   32  store data from the memory/IO mux
//     led        out  16  LED drive, active high
//     seg_an     out  8   digit anodes, active low, one-hot
//     seg_cat    out  8   cathodes {dp,g,f,e,d,c,b,a}, active low
//     disp_val   out  32  readback of the latched display value
// ----------------------------------------------------------------------------
module io_out_driver
    import io_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter bit          BLANK_LEAD = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        led_ctrl,
    input  logic        seg_ctrl,
    input  logic [31:0] w_dat,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat,
    output logic [31:0] disp_val
);

    localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       dig_idx;
    logic [31:0]      upper;
    logic [3:0]       nibble;
    logic [7:0]       glyph;
    logic             slot_end;
    logic             blank;
    logic [7:0]       an_next;
    logic [7:0]       cat_next;

    // Store latches: each strobe re-latches every cycle it is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led      <= '0;
            disp_val <= '0;
        end else begin
            if (led_ctrl) led      <= w_dat[15:0];
            if (seg_ctrl) disp_val <= w_dat;
        end
    end

    // Slot timer and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == LAST_CNT) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    seg7_decode u_decode (
        .nibble  (nibble),
        .cathode (glyph)
    );

    // The anode is forced off on the last count of a slot so that, after the
    // one-cycle output register, it is dark exactly while scan_cnt==0 and the
    // digit index has just moved on. Digit i is a leading zero when all
    // nibbles from i upward are zero, i.e. disp_val >> 4*i is zero.
    always_comb begin
        upper    = disp_val >> {dig_idx, 2'b00};
        nibble   = upper[3:0];
        slot_end = (scan_cnt == LAST_CNT);
        blank    = BLANK_LEAD && (dig_idx != 3'd0) && (upper == '0);
        an_next  = (slot_end || blank) ? SEG_OFF_AN : ~(8'b1 << dig_idx);
        cat_next = blank ? SEG_BLANK : glyph;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_an  <= SEG_OFF_AN;
            seg_cat <= SEG_BLANK;
        end else begin
            seg_an  <= an_next;
            seg_cat <= cat_next;
        end
    end

endmodule
